// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and FSM state type for the register-file write arbiter
package regfile_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_ARB   = 1'b1
  } rfarb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr_i; one-hot grant plus winner index
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    found    = 1'b0;
    grant_o  = '0;
    winner_o = '0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        winner_o      = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - zeroing sweep then round-robin sharing of the register file write port
module regfile_write_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = regfile_pkg::AW,
  parameter int DW      = regfile_pkg::DW,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         init_req,
  output logic                         busy,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0][AW-1:0]      req_addr,
  input  logic [NREQ-1:0][DW-1:0]      req_data,
  output logic                         rf_regwrite,
  output logic [AW-1:0]                rf_writereg,
  output logic [DW-1:0]                rf_data,
  output logic [$clog2(NREQ)-1:0]      grant_id
);

  import regfile_pkg::*;

  localparam int IW = $clog2(NREQ);

  rfarb_state_t  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] gid_q, gid_d;

  logic [NREQ-1:0] arb_valid;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   winner;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  // init_req in arbitration blocks the grant so nothing is lost when the sweep starts
  assign arb_valid = (state_q == ST_ARB && !init_req) ? req_valid : '0;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (
    .valid_i  (arb_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (winner)
  );

  assign accept   = |grant;
  assign sel_addr = req_addr[winner];
  assign sel_data = req_data[winner];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    we_d    = 1'b0;
    wr_d    = '0;
    data_d  = '0;
    if (state_q == ST_SWEEP) begin
      // the sweep ends once the last register's write is already on the outputs
      if (we_q && wr_q == AW'(NREG - 1)) begin
        state_d = ST_ARB;
        idx_d   = '0;
      end else begin
        we_d  = 1'b1;
        wr_d  = idx_q;
        idx_d = idx_q + 1'b1;
      end
    end else begin
      if (accept) begin
        gid_d = winner;
        ptr_d = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
        if (!(ZERO_R0 && sel_addr == '0)) begin
          we_d   = 1'b1;
          wr_d   = sel_addr;
          data_d = sel_data;
        end
      end
      if (init_req) begin
        state_d = ST_SWEEP;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_SWEEP;
      idx_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign busy        = (state_q == ST_SWEEP);
  assign req_ready   = grant;
  assign rf_regwrite = we_q;
  assign rf_writereg = wr_q;
  assign rf_data     = data_q;
  assign grant_id    = gid_q;

endmodule
